wb_arbiter_n: RTL and testbench
===============================

# wb_arbiter_n

Parametrised N-master to 1-slave Wishbone classic-cycle arbiter with selectable fixed-priority or round-robin grant and a per-transfer ack timeout watchdog. It sits between several bus masters (host interface, DMA engines, test masters) and a single slave or interconnect port. Ownership is held for a whole CYC burst and released only at a clean cycle boundary. A hung slave cannot lock the bus: the owner is terminated with ERR after a programmable number of cycles.

## Interface
- NUM_MASTERS, 4: number of master ports, 2..16.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width, multiple of 8.
- SEL_WIDTH, DATA_WIDTH/8: byte-select width.
- ROUND_ROBIN, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 256: cycles of STB without ACK before abort; 0 disables the watchdog.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_m_we  in  NUM_MASTERS  per-master write enable, bit k = master k.
- i_m_cyc  in  NUM_MASTERS  per-master cycle request.
- i_m_stb  in  NUM_MASTERS  per-master strobe.
- i_m_sel  in  NUM_MASTERS*SEL_WIDTH  packed selects; master k at [k*SEL_WIDTH +: SEL_WIDTH].
- i_m_adr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, same packing.
- i_m_dat  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing.
- o_m_ack  out  NUM_MASTERS  ack, routed only to the owner.
- o_m_err  out  NUM_MASTERS  one-cycle timeout error to the owner.
- o_m_int  out  NUM_MASTERS  slave interrupt, routed only to the owner.
- o_m_dat  out  DATA_WIDTH  read data, broadcast to all masters.
- o_s_we, o_s_stb, o_s_cyc  out  1  slave control from the owner.
- o_s_sel  out  SEL_WIDTH  slave byte select.
- o_s_adr  out  ADDR_WIDTH  slave address.
- o_s_dat  out  DATA_WIDTH  slave write data.
- i_s_dat  in  DATA_WIDTH  slave read data.
- i_s_ack  in  1  slave ack.
- i_s_int  in  1  slave interrupt.
- o_grant  out  NUM_MASTERS  registered one-hot owner; 0 when no owner.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, OWN, ABORT.
- **IDLE**
  - All slave outputs are 0.
  - If any i_m_cyc is high, register a grant to the winner and go to OWN.
  - Fixed mode: the lowest index wins.
  - Round-robin mode: search starts at last_grant+1 and wraps modulo NUM_MASTERS.
  - last_grant updates on every grant.
- **OWN**
  - Slave outputs are a combinational mux of the owner's inputs.
  - o_m_ack[owner] = i_s_ack; o_m_int[owner] = i_s_int; all other ack/int bits are 0.
  - Release to IDLE when owner cyc is 0 and i_s_ack is 0 in the same cycle.
  - If the owner drops cyc while i_s_ack is high, stay in OWN one more cycle.
  - There is no preemption: requests from other masters are ignored while a master owns the bus.
- **Watchdog**
  - The counter clears on entering OWN and on every cycle with i_s_ack high or owner stb low.
  - It increments on each cycle with owner stb high and i_s_ack low.
  - When the count equals TIMEOUT-1 and i_s_ack is low: assert o_m_err[owner] and o_timeout for that cycle, then go to ABORT.
- **ABORT**
  - o_s_cyc and o_s_stb are forced to 0; o_grant holds the owner.
  - Late i_s_ack is not forwarded.
  - Return to IDLE when owner cyc is 0.
- **Reset** (at any time, including mid-transfer)
  - State goes to IDLE; o_grant, all slave outputs, o_m_ack, o_m_err, o_m_int and o_timeout are 0.
  - Watchdog count is 0; last_grant = NUM_MASTERS-1, so master 0 has first priority.
- o_m_dat = i_s_dat at all times.

## Timing
- Grant latency: cyc sampled high at edge t gives o_grant and o_s_cyc valid after edge t, i.e. 1 cycle.
- Release: owner cyc sampled low (no ack) at edge r puts the arbiter in IDLE after r. The next grant is visible after edge r+1, so there is one mandatory dead cycle between owners.
- Ack and data path are combinational, with zero added latency.
- Watchdog: with stb continuously high and no ack from the first OWN cycle, err asserts in OWN cycle TIMEOUT (1-based).

## Test plan
- **Single master:** m2 writes adr 0x10, dat 0xDEADBEEF; slave acks on the 2nd cycle. Required: o_s_adr=0x10, o_s_dat=0xDEADBEEF, o_m_ack=4'b0100, o_grant=4'b0100.
- **Round-robin fairness:** all 4 masters hold cyc, each releasing after one ack. Required grant order 0,1,2,3,0, with one idle cycle between grants.
- **Fixed priority** (ROUND_ROBIN=0): m0 and m3 request continuously. m0 regains the bus every time; m3 is granted only when m0 drops cyc.
- **Timeout** (TIMEOUT=8): m1 strobes, slave never acks. Required: o_m_err[1] and o_timeout pulse in OWN cycle 8, o_s_cyc drops the next cycle, and the arbiter returns to IDLE after m1 drops cyc.
- **Release with ack:** owner drops cyc in the same cycle as i_s_ack. Ownership must be held one extra cycle, and no other master sees an ack.
- **Reset mid-burst:** assert rst while m3 owns and stb is high. After the edge: o_s_cyc=0, o_grant=0, and the next arbitration favours m0.

Source files
------------

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic-cycle arbiter. Grants are fixed-priority or round-robin,
// ownership lasts a whole CYC burst, and a watchdog aborts transfers whose slave never acks.
module wb_arbiter_n #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            i_m_we,
    input  logic [NUM_MASTERS-1:0]            i_m_cyc,
    input  logic [NUM_MASTERS-1:0]            i_m_stb,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  i_m_sel,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_dat,
    output logic [NUM_MASTERS-1:0]            o_m_ack,
    output logic [NUM_MASTERS-1:0]            o_m_err,
    output logic [NUM_MASTERS-1:0]            o_m_int,
    output logic [DATA_WIDTH-1:0]             o_m_dat,
    output logic                              o_s_we,
    output logic                              o_s_stb,
    output logic                              o_s_cyc,
    output logic [SEL_WIDTH-1:0]              o_s_sel,
    output logic [ADDR_WIDTH-1:0]             o_s_adr,
    output logic [DATA_WIDTH-1:0]             o_s_dat,
    input  logic [DATA_WIDTH-1:0]             i_s_dat,
    input  logic                              i_s_ack,
    input  logic                              i_s_int,
    output logic [NUM_MASTERS-1:0]            o_grant,
    output logic                              o_timeout
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_ABORT
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [WD_W-1:0]        wd_q, wd_d;

    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   found;

    logic                   own_cyc, own_stb, own_we;
    logic [SEL_WIDTH-1:0]   own_sel;
    logic [ADDR_WIDTH-1:0]  own_adr;
    logic [DATA_WIDTH-1:0]  own_dat;

    // Winner search: round-robin starts just after the last grant, fixed starts at master 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ROUND_ROBIN != 0) begin
                cand = IDX_W'((int'(last_q) + 1 + i) % NUM_MASTERS);
            end else begin
                cand = IDX_W'(i);
            end
            if (!found && i_m_cyc[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (owner_q == IDX_W'(k)) begin
                own_cyc = i_m_cyc[k];
                own_stb = i_m_stb[k];
                own_we  = i_m_we[k];
                own_sel = i_m_sel[k*SEL_WIDTH +: SEL_WIDTH];
                own_adr = i_m_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
                own_dat = i_m_dat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant_d   = grant_q;
        wd_d      = '0;
        o_m_ack   = '0;
        o_m_err   = '0;
        o_m_int   = '0;
        o_s_we    = 1'b0;
        o_s_stb   = 1'b0;
        o_s_cyc   = 1'b0;
        o_s_sel   = '0;
        o_s_adr   = '0;
        o_s_dat   = '0;
        o_timeout = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|i_m_cyc) begin
                    state_d = ST_OWN;
                    owner_d = winner;
                    last_d  = winner;
                    grant_d = NUM_MASTERS'(1) << winner;
                end
            end

            ST_OWN: begin
                o_s_cyc = own_cyc;
                o_s_stb = own_stb;
                o_s_we  = own_we;
                o_s_sel = own_sel;
                o_s_adr = own_adr;
                o_s_dat = own_dat;
                // grant_q is the one-hot owner, so masking routes ack/int to the owner only.
                o_m_ack = grant_q & {NUM_MASTERS{i_s_ack}};
                o_m_int = grant_q & {NUM_MASTERS{i_s_int}};

                if (own_stb && !i_s_ack) begin
                    wd_d = wd_q + WD_W'(1);
                end

                if (!own_cyc && !i_s_ack) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if ((TIMEOUT != 0) && own_stb && !i_s_ack && (wd_q == WD_LAST)) begin
                    o_m_err   = grant_q;
                    o_timeout = 1'b1;
                    state_d   = ST_ABORT;
                    wd_d      = '0;
                end
            end

            ST_ABORT: begin
                // The owner keeps the grant until it drops CYC; a late ack is swallowed.
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign o_m_dat = i_s_dat;
    assign o_grant = grant_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RESET;
            grant_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: one round-robin and one fixed-priority instance share
// the same master/slave stimulus; each scenario checks the instance it targets.
module tb_wb_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  m_we, m_cyc, m_stb;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_int;

    logic [N-1:0]  rr_m_ack, rr_m_err, rr_m_int, rr_grant;
    logic [DW-1:0] rr_m_dat, rr_s_dat;
    logic          rr_s_we, rr_s_stb, rr_s_cyc, rr_timeout;
    logic [SW-1:0] rr_s_sel;
    logic [AW-1:0] rr_s_adr;

    logic [N-1:0]  fx_m_ack, fx_m_err, fx_m_int, fx_grant;
    logic [DW-1:0] fx_m_dat, fx_s_dat;
    logic          fx_s_we, fx_s_stb, fx_s_cyc, fx_timeout;
    logic [SW-1:0] fx_s_sel;
    logic [AW-1:0] fx_s_adr;

    wb_arbiter_n #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .ROUND_ROBIN(1), .TIMEOUT(TO)
    ) dut_rr (
        .clk(clk), .rst(rst),
        .i_m_we(m_we), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_sel(m_sel),
        .i_m_adr(m_adr), .i_m_dat(m_dat),
        .o_m_ack(rr_m_ack), .o_m_err(rr_m_err), .o_m_int(rr_m_int), .o_m_dat(rr_m_dat),
        .o_s_we(rr_s_we), .o_s_stb(rr_s_stb), .o_s_cyc(rr_s_cyc), .o_s_sel(rr_s_sel),
        .o_s_adr(rr_s_adr), .o_s_dat(rr_s_dat),
        .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_int(s_int),
        .o_grant(rr_grant), .o_timeout(rr_timeout)
    );

    wb_arbiter_n #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .ROUND_ROBIN(0), .TIMEOUT(TO)
    ) dut_fx (
        .clk(clk), .rst(rst),
        .i_m_we(m_we), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_sel(m_sel),
        .i_m_adr(m_adr), .i_m_dat(m_dat),
        .o_m_ack(fx_m_ack), .o_m_err(fx_m_err), .o_m_int(fx_m_int), .o_m_dat(fx_m_dat),
        .o_s_we(fx_s_we), .o_s_stb(fx_s_stb), .o_s_cyc(fx_s_cyc), .o_s_sel(fx_s_sel),
        .o_s_adr(fx_s_adr), .o_s_dat(fx_s_dat),
        .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_int(s_int),
        .o_grant(fx_grant), .o_timeout(fx_timeout)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled after a further 1 ns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        m_we   = '0;
        m_cyc  = '0;
        m_stb  = '0;
        m_sel  = '0;
        m_adr  = '0;
        m_dat  = '0;
        s_rdat = '0;
        s_ack  = 1'b0;
        s_int  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One single-beat burst by master m: grant, ack on the first owned cycle, drop CYC,
    // then the mandatory dead cycle. Optionally re-requests for the next round.
    task automatic burst(input string tag, input int m, input bit fx, input bit again);
        logic [N-1:0] exp_oh;
        exp_oh = 4'b0001 << m;
        step();
        check({tag, "_grant"}, 64'(fx ? fx_grant : rr_grant), 64'(exp_oh));
        s_ack = 1'b1;
        settle();
        check({tag, "_ack"}, 64'(fx ? fx_m_ack : rr_m_ack), 64'(exp_oh));
        step();
        s_ack    = 1'b0;
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        settle();
        check({tag, "_hold"}, 64'(fx ? fx_grant : rr_grant), 64'(exp_oh));
        step();
        check({tag, "_dead"}, 64'(fx ? fx_grant : rr_grant), 64'(0));
        if (again) begin
            m_cyc[m] = 1'b1;
            m_stb[m] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        settle();
        check("rst_grant",   64'(rr_grant),   64'(0));
        check("rst_s_cyc",   64'(rr_s_cyc),   64'(0));
        check("rst_m_ack",   64'(rr_m_ack),   64'(0));
        check("rst_timeout", 64'(rr_timeout), 64'(0));
        check("rst_fx_grant", 64'(fx_grant),  64'(0));

        // Single master: m2 write, slave acks on the 2nd owned cycle
        do_reset();
        m_cyc = 4'b0100;
        m_stb = 4'b0100;
        m_we  = 4'b0100;
        m_sel[2*SW +: SW] = 4'hF;
        m_adr[2*AW +: AW] = 32'h0000_0010;
        m_dat[2*DW +: DW] = 32'hDEAD_BEEF;
        s_rdat = 32'hCAFE_F00D;
        step();
        settle();
        check("single_grant", 64'(rr_grant), 64'(4'b0100));
        check("single_s_cyc", 64'(rr_s_cyc), 64'(1));
        check("single_s_we",  64'(rr_s_we),  64'(1));
        check("single_s_sel", 64'(rr_s_sel), 64'(4'hF));
        check("single_s_adr", 64'(rr_s_adr), 64'(32'h10));
        check("single_s_dat", 64'(rr_s_dat), 64'(32'hDEAD_BEEF));
        check("single_noack", 64'(rr_m_ack), 64'(0));
        step();
        s_ack = 1'b1;
        s_int = 1'b1;
        settle();
        check("single_ack",   64'(rr_m_ack), 64'(4'b0100));
        check("single_int",   64'(rr_m_int), 64'(4'b0100));
        check("single_m_dat", 64'(rr_m_dat), 64'(32'hCAFE_F00D));
        step();
        s_ack = 1'b0;
        s_int = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        step();
        settle();
        check("single_release", 64'(rr_grant), 64'(0));

        // Round-robin fairness: all four request, expected order 0,1,2,3,0
        do_reset();
        m_cyc = 4'hF;
        m_stb = 4'hF;
        burst("rr0", 0, 1'b0, 1'b1);
        burst("rr1", 1, 1'b0, 1'b1);
        burst("rr2", 2, 1'b0, 1'b1);
        burst("rr3", 3, 1'b0, 1'b1);
        burst("rr4", 0, 1'b0, 1'b1);

        // Fixed priority: m0 keeps winning over m3 until it stops requesting
        do_reset();
        m_cyc = 4'b1001;
        m_stb = 4'b1001;
        burst("fx0", 0, 1'b1, 1'b1);
        burst("fx1", 0, 1'b1, 1'b1);
        burst("fx2", 0, 1'b1, 1'b0);
        step();
        check("fx_m3_grant", 64'(fx_grant), 64'(4'b1000));

        // Watchdog: m1 strobes and the slave never acks
        do_reset();
        m_cyc = 4'b0010;
        m_stb = 4'b0010;
        for (int c = 1; c <= TO; c++) begin
            step();
            if (c < TO) begin
                check($sformatf("to_cyc%0d_err", c), 64'(rr_m_err), 64'(0));
            end else begin
                check("to_err",        64'(rr_m_err),   64'(4'b0010));
                check("to_pulse",      64'(rr_timeout), 64'(1));
                check("to_fx_pulse",   64'(fx_timeout), 64'(1));
                check("to_s_cyc_last", 64'(rr_s_cyc),   64'(1));
            end
        end
        step();
        check("abort_s_cyc",   64'(rr_s_cyc),   64'(0));
        check("abort_s_stb",   64'(rr_s_stb),   64'(0));
        check("abort_grant",   64'(rr_grant),   64'(4'b0010));
        check("abort_err_off", 64'(rr_m_err),   64'(0));
        check("abort_to_off",  64'(rr_timeout), 64'(0));
        s_ack = 1'b1;
        settle();
        check("abort_late_ack", 64'(rr_m_ack), 64'(0));
        step();
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        step();
        check("abort_idle", 64'(rr_grant), 64'(0));

        // Release with ack: m0 drops CYC in the ack cycle while m1 waits
        do_reset();
        m_cyc = 4'b0011;
        m_stb = 4'b0011;
        step();
        check("rwa_grant", 64'(rr_grant), 64'(4'b0001));
        s_ack    = 1'b1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        settle();
        check("rwa_ack", 64'(rr_m_ack), 64'(4'b0001));
        step();
        s_ack = 1'b0;
        settle();
        check("rwa_hold",   64'(rr_grant), 64'(4'b0001));
        check("rwa_no_ack", 64'(rr_m_ack), 64'(0));
        step();
        check("rwa_dead", 64'(rr_grant), 64'(0));
        step();
        check("rwa_next", 64'(rr_grant), 64'(4'b0010));

        // Reset mid-burst: m3 owns with STB high, then m0 and m3 both request
        do_reset();
        m_cyc = 4'b1000;
        m_stb = 4'b1000;
        step();
        check("mid_grant", 64'(rr_grant), 64'(4'b1000));
        check("mid_s_stb", 64'(rr_s_stb), 64'(1));
        rst   = 1'b1;
        m_cyc = 4'b1001;
        m_stb = 4'b1001;
        step();
        check("mid_rst_s_cyc", 64'(rr_s_cyc), 64'(0));
        check("mid_rst_grant", 64'(rr_grant), 64'(0));
        rst = 1'b0;
        step();
        check("mid_after_m0", 64'(rr_grant), 64'(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
